// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer
//   Per-cycle trace recorder for the pipelined MIPS core. Each qualified cycle
//   captures {timestamp, hazard flags, all stage instructions, all stage PCs}
//   into a circular buffer. Capture ends on stop, a full buffer (FILL), or a
//   PC trigger plus a post-trigger window (TRIG). The buffer then drains
//   oldest-first through a valid/ready port.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   start        pulse: clear buffer, latch mode/trig_pc, begin capture
//   stop         pulse: end capture (ignored in IDLE/DONE)
//   mode         0 WRAP, 1 FILL, 2 TRIG, 3 behaves as WRAP
//   trig_pc      trigger PC compared against stage TRIG_STAGE
//   cap_en       capture qualifier
//   stage_pc     stage PCs, stage i at [i*PC_W +: PC_W]
//   stage_instr  stage instructions, same packing
//   flags        hazard/forward flag vector
//   rd_valid     rd_data holds an unread entry
//   rd_ready     consumer accepts rd_data
//   rd_data      {ts, flags, instr[S-1..0], pc[S-1..0]}
//   count        stored entries, 0..DEPTH
//   busy         capturing (CAPTURE or POST)
//   done         capture finished, readout available
//   triggered    trigger seen during this capture (sticky)
//   overflow     an entry was overwritten during this capture (sticky)

module pipe_trace_buffer #(
    parameter int STAGES     = 5,
    parameter int PC_W       = 32,
    parameter int INSTR_W    = 32,
    parameter int FLAG_W     = 8,
    parameter int DEPTH      = 16,
    parameter int TS_W       = 16,
    parameter int TRIG_STAGE = 3,
    parameter int POST_CNT   = 4,
    parameter int ENTRY_W    = TS_W + FLAG_W + STAGES * (PC_W + INSTR_W)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stop,
    input  logic [1:0]                  mode,
    input  logic [PC_W-1:0]             trig_pc,
    input  logic                        cap_en,
    input  logic [STAGES*PC_W-1:0]      stage_pc,
    input  logic [STAGES*INSTR_W-1:0]   stage_instr,
    input  logic [FLAG_W-1:0]           flags,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [ENTRY_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        busy,
    output logic                        done,
    output logic                        triggered,
    output logic                        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0] POST_LD  = AW'(POST_CNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        POST    = 2'd2,
        DONE    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        M_WRAP = 2'd0,
        M_FILL = 2'd1,
        M_TRIG = 2'd2,
        M_RSVD = 2'd3
    } mode_e;

    state_e             state;
    mode_e              mode_q;
    logic [PC_W-1:0]    trig_pc_q;
    logic [TS_W-1:0]    ts;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      post_left;
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic               capturing;
    logic               wr_en;
    logic               full;
    logic               trig_hit;
    logic               go_done;
    logic [AW-1:0]      wr_ptr_nxt;
    logic [CW-1:0]      count_nxt;
    logic [ENTRY_W-1:0] entry;

    assign entry = {ts, flags, stage_instr, stage_pc};

    always_comb begin
        capturing  = (state == CAPTURE) || (state == POST);
        wr_en      = reset && !start && capturing && cap_en;
        full       = (count == FULL_CNT);
        wr_ptr_nxt = wr_ptr;
        count_nxt  = count;
        if (wr_en) begin
            wr_ptr_nxt = wr_ptr + AW'(1);
            if (!full) begin
                count_nxt = count + CW'(1);
            end
        end
        // Only a pre-trigger write can match; POST already implies triggered.
        trig_hit = wr_en && (state == CAPTURE) && (mode_q == M_TRIG) && !triggered
                   && (stage_pc[TRIG_STAGE*PC_W +: PC_W] == trig_pc_q);
        go_done  = stop
                   || (wr_en && (mode_q == M_FILL) && (count_nxt == FULL_CNT))
                   || (trig_hit && (POST_CNT == 0))
                   || (wr_en && (state == POST) && (post_left == AW'(1)));
    end

    // Storage has no reset; readout is gated by rd_valid instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            mode_q    <= M_WRAP;
            trig_pc_q <= '0;
            ts        <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_left <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            triggered <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            ts <= ts + TS_W'(1);
            if (start) begin
                state     <= CAPTURE;
                mode_q    <= mode_e'(mode);
                trig_pc_q <= trig_pc;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                post_left <= '0;
                busy      <= 1'b1;
                done      <= 1'b0;
                triggered <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                unique case (state)
                    CAPTURE, POST: begin
                        wr_ptr <= wr_ptr_nxt;
                        count  <= count_nxt;
                        if (wr_en && full) begin
                            overflow <= 1'b1;
                        end
                        if (trig_hit) begin
                            triggered <= 1'b1;
                        end
                        if (go_done) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            // Oldest entry, computed from the post-write pointers.
                            rd_ptr <= wr_ptr_nxt - count_nxt[AW-1:0];
                        end else if (trig_hit) begin
                            state     <= POST;
                            post_left <= POST_LD;
                        end else if (wr_en && (state == POST)) begin
                            post_left <= post_left - AW'(1);
                        end
                    end
                    DONE: begin
                        if (rd_valid && rd_ready) begin
                            rd_ptr <= rd_ptr + AW'(1);
                            count  <= count - CW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rd_valid = done && (count != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb_pipe_trace_buffer
//   Directed bench for pipe_trace_buffer: WRAP with overwrite, FILL stop at
//   full, TRIG with post window and backpressured drain, start+stop while
//   DONE, and reset in the middle of POST followed by a fresh capture.

module tb_pipe_trace_buffer;

    localparam int STAGES     = 5;
    localparam int PC_W       = 32;
    localparam int INSTR_W    = 32;
    localparam int FLAG_W     = 8;
    localparam int DEPTH      = 16;
    localparam int TS_W       = 16;
    localparam int TRIG_STAGE = 3;
    localparam int POST_CNT   = 4;
    localparam int ENTRY_W    = TS_W + FLAG_W + STAGES * (PC_W + INSTR_W);

    logic                       clk;
    logic                       reset;
    logic                       start;
    logic                       stop;
    logic [1:0]                 mode;
    logic [PC_W-1:0]            trig_pc;
    logic                       cap_en;
    logic [STAGES*PC_W-1:0]     stage_pc;
    logic [STAGES*INSTR_W-1:0]  stage_instr;
    logic [FLAG_W-1:0]          flags;
    logic                       rd_valid;
    logic                       rd_ready;
    logic [ENTRY_W-1:0]         rd_data;
    logic [$clog2(DEPTH):0]     count;
    logic                       busy;
    logic                       done;
    logic                       triggered;
    logic                       overflow;

    pipe_trace_buffer #(
        .STAGES     (STAGES),
        .PC_W       (PC_W),
        .INSTR_W    (INSTR_W),
        .FLAG_W     (FLAG_W),
        .DEPTH      (DEPTH),
        .TS_W       (TS_W),
        .TRIG_STAGE (TRIG_STAGE),
        .POST_CNT   (POST_CNT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .trig_pc     (trig_pc),
        .cap_en      (cap_en),
        .stage_pc    (stage_pc),
        .stage_instr (stage_instr),
        .flags       (flags),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .triggered   (triggered),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected timestamp register value before the next rising edge.
    logic [TS_W-1:0]    ts_m = '0;
    logic [ENTRY_W-1:0] rec [1:32];

    task automatic check(input string tag, input logic [ENTRY_W-1:0] got,
                         input logic [ENTRY_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) ts_m = '0;
        else        ts_m = ts_m + 16'd1;
        #1;
    endtask

    // Stage i PC = 0x3000 + 4*(k+i-9): stage 3 shows 0x3010 only on write 10.
    task automatic apply(input int k);
        for (int unsigned i = 0; i < STAGES; i++) begin
            stage_pc[i*PC_W +: PC_W]          = 32'h3000 + 32'(4 * (k + int'(i) - 9));
            stage_instr[i*INSTR_W +: INSTR_W] = {16'(k), 8'(i), 8'hA5};
        end
        flags = 8'(k) ^ 8'h5A;
    endtask

    task automatic cap(input int k);
        apply(k);
        cap_en = 1'b1;
        rec[k] = {ts_m, flags, stage_instr, stage_pc};
        step();
        cap_en = 1'b0;
    endtask

    task automatic begin_capture(input logic [1:0] m, input logic [PC_W-1:0] tpc);
        mode    = m;
        trig_pc = tpc;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic end_capture();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic drain(input string name, input int first, input int n);
        rd_ready = 1'b1;
        for (int j = 0; j < n; j++) begin
            check($sformatf("%s_valid%0d", name, j), rd_valid, 1'b1);
            check($sformatf("%s_data%0d", name, j), rd_data, rec[first + j]);
            step();
            check($sformatf("%s_count%0d", name, j), count, n - 1 - j);
        end
        rd_ready = 1'b0;
        check({name, "_valid_end"}, rd_valid, 1'b0);
        check({name, "_done_end"}, done, 1'b1);
    endtask

    initial begin
        int idx;
        int c;
        logic [3:0] pat;

        reset       = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        mode        = 2'd0;
        trig_pc     = '0;
        cap_en      = 1'b0;
        stage_pc    = '0;
        stage_instr = '0;
        flags       = '0;
        rd_ready    = 1'b0;
        step();
        step();

        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_data", rd_data, '0);
        check("rst_count", count, 0);
        check("rst_trig", triggered, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        reset = 1'b1;
        step();

        // WRAP: 20 writes into 16 slots, oldest kept is write 5.
        begin_capture(2'd0, 32'h3010);
        check("wrap_busy", busy, 1'b1);
        check("wrap_count0", count, 0);
        for (int k = 1; k <= 20; k++) cap(k);
        check("wrap_count_sat", count, 16);
        check("wrap_ovf", overflow, 1'b1);
        check("wrap_no_trig", triggered, 1'b0);
        check("wrap_ts_offset", rec[5][ENTRY_W-1 -: TS_W], rec[1][ENTRY_W-1 -: TS_W] + 16'd4);
        end_capture();
        check("wrap_done", done, 1'b1);
        check("wrap_busy_off", busy, 1'b0);
        drain("wrap", 5, 16);

        // FILL: stops at the 16th write; later inputs never stored.
        begin_capture(2'd1, 32'h0);
        for (int k = 1; k <= 30; k++) begin
            cap(k);
            if (k == 15) check("fill_not_done15", done, 1'b0);
            if (k == 16) check("fill_done16", done, 1'b1);
        end
        check("fill_count", count, 16);
        check("fill_ovf", overflow, 1'b0);
        drain("fill", 1, 16);

        // TRIG: match on write 10, 4 post writes, done after write 14.
        begin_capture(2'd2, 32'h0000_3010);
        for (int k = 1; k <= 20; k++) begin
            cap(k);
            if (k == 9)  check("trig_not_yet", triggered, 1'b0);
            if (k == 10) check("trig_seen", triggered, 1'b1);
            if (k == 13) check("trig_busy13", busy, 1'b1);
            if (k == 14) check("trig_done14", done, 1'b1);
        end
        check("trig_count", count, 14);
        check("trig_ovf", overflow, 1'b0);

        // Backpressured drain: rd_ready pattern 1,0,0,1.
        pat = 4'b1001;
        idx = 1;
        c   = 0;
        while (idx <= 14 && c < 100) begin
            rd_ready = pat[3 - (c % 4)];
            check($sformatf("trig_valid_c%0d", c), rd_valid, 1'b1);
            check($sformatf("trig_data_c%0d", c), rd_data, rec[idx]);
            if (idx == 10)
                check("trig_entry_pc", rd_data[TRIG_STAGE*PC_W +: PC_W], 32'h0000_3010);
            if (rd_ready) idx++;
            step();
            c++;
        end
        rd_ready = 1'b0;
        check("trig_drain_bound", idx, 15);
        check("trig_valid_end", rd_valid, 1'b0);
        check("trig_count_end", count, 0);

        // start and stop together while DONE: start wins.
        mode    = 2'd2;
        trig_pc = 32'h0000_3010;
        start   = 1'b1;
        stop    = 1'b1;
        step();
        start   = 1'b0;
        stop    = 1'b0;
        check("ss_busy", busy, 1'b1);
        check("ss_done", done, 1'b0);
        check("ss_count", count, 0);
        check("ss_trig", triggered, 1'b0);
        check("ss_ovf", overflow, 1'b0);

        // Reset in the middle of POST.
        for (int k = 1; k <= 12; k++) cap(k);
        check("post_trig", triggered, 1'b1);
        check("post_busy", busy, 1'b1);
        check("post_count", count, 12);
        reset = 1'b0;
        step();
        check("mr_busy", busy, 1'b0);
        check("mr_done", done, 1'b0);
        check("mr_valid", rd_valid, 1'b0);
        check("mr_data", rd_data, '0);
        check("mr_count", count, 0);
        check("mr_trig", triggered, 1'b0);
        check("mr_ovf", overflow, 1'b0);
        reset = 1'b1;
        step();

        // Fresh WRAP capture after the reset.
        begin_capture(2'd0, 32'h0);
        for (int k = 1; k <= 3; k++) cap(k);
        check("again_count", count, 3);
        end_capture();
        check("again_done", done, 1'b1);
        drain("again", 1, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_trace_buffer.md
# pipe_trace_buffer

Synthesizable per-cycle trace recorder for the pipelined MIPS core: captures PC, instruction and a hazard-flag vector for every pipeline stage into a circular buffer, then drains it oldest-first through a valid/ready port. It sits beside `mips`, tapped onto the stage registers and the stall/forward selects, and gives the bench or on-chip debug logic one uniform readout. It replaces per-stage hierarchical peeking with a bounded, mode-controlled capture window.

## Interface
- STAGES, 5, number of pipeline stages traced (stage 0 = F).
- PC_W, 32, PC width per stage.
- INSTR_W, 32, instruction width per stage.
- FLAG_W, 8, hazard/forward flag vector width (stall, forward selects).
- DEPTH, 16, entry count; power of two, at least 2.
- TS_W, 16, timestamp width.
- TRIG_STAGE, 3, stage whose PC is compared in trigger mode.
- POST_CNT, 4, entries captured after the trigger entry, at most DEPTH-1.
- ENTRY_W, derived: TS_W + FLAG_W + STAGES*(PC_W+INSTR_W).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  reset, synchronous, active-low.
- start  in  1  pulse: clear buffer and begin capture.
- stop  in  1  pulse: end capture.
- mode  in  2  0 WRAP, 1 FILL, 2 TRIG, 3 reserved (behaves as WRAP); sampled on start.
- trig_pc  in  PC_W  trigger PC, sampled on start.
- cap_en  in  1  capture qualifier (deasserted while the core is in reset).
- stage_pc  in  STAGES*PC_W  stage PCs, stage i at bits [i*PC_W +: PC_W].
- stage_instr  in  STAGES*INSTR_W  stage instructions, same packing.
- flags  in  FLAG_W  hazard flags.
- rd_valid  out  1  rd_data holds an unread entry.
- rd_ready  in  1  consumer accepts rd_data.
- rd_data  out  ENTRY_W  {ts, flags, instr[S-1..0], pc[S-1..0]}.
- count  out  clog2(DEPTH)+1  stored entries, 0..DEPTH.
- busy  out  1  in CAPTURE or POST.
- done  out  1  in DONE.
- triggered  out  1  trigger seen during this capture (sticky).
- overflow  out  1  an entry was overwritten during this capture (sticky).

## Operation
- States: IDLE, CAPTURE, POST, DONE.
- Timestamp: free-running TS_W counter; +1 every cycle after reset; wraps modulo 2^TS_W.
- Write: in CAPTURE or POST, when cap_en=1, store the entry at wr_ptr, then wr_ptr <= wr_ptr+1 mod DEPTH; count <= min(count+1, DEPTH).
- WRAP: when count=DEPTH, each write overwrites the oldest entry and sets overflow. Exits only on stop.
- FILL: the write that makes count=DEPTH moves to DONE. No overwrite.
- TRIG: pre-trigger behaves as WRAP. A write whose stage TRIG_STAGE PC equals trig_pc sets triggered and moves to POST with post counter = POST_CNT. If POST_CNT=0, it moves to DONE instead. Each POST write decrements the counter; the write at counter 1 moves to DONE. Only the first match counts.
- stop in CAPTURE/POST: a same-cycle write still happens, then DONE. stop in IDLE or DONE is ignored.
- start in any state: ptrs, count, triggered, overflow and post counter cleared; mode and trig_pc latched; next state CAPTURE. No write in the start cycle. start beats stop.
- DONE readout: rd_ptr initialised to (wr_ptr-count) mod DEPTH on entry. rd_valid = (count≠0). rd_data = mem[rd_ptr], combinational read. On rd_valid&rd_ready: rd_ptr+1 mod DEPTH, count-1. After the last entry, rd_valid=0 and the block stays DONE.
- IDLE/DONE: no writes regardless of cap_en.

## Timing
- Reset (reset=0 at an edge): state IDLE; ts, count, wr_ptr, rd_ptr, post counter = 0; rd_valid, busy, done, triggered, overflow = 0; rd_data = 0 (memory contents undefined, output gated while IDLE).
- Capture latency: inputs at edge N are stored at edge N; count reflects the write after edge N.
- done rises the cycle after the terminating write or stop. rd_valid rises in the same cycle when count>0.
- Reading: one entry per cycle with rd_ready held high.
- rd_data is stable while rd_valid=1 and rd_ready=0.
- A reset mid-capture or mid-readout discards everything within one cycle.

## Test plan
- WRAP, DEPTH=16: start, 20 cap_en cycles, stop, drain with rd_ready=1 -> exactly 16 entries with ts consecutive, first ts = first-capture ts+4; overflow=1; count 16->0.
- FILL: start, cap_en for 30 cycles -> done after the 16th write; 16 entries read; overflow=0; later inputs absent.
- TRIG, POST_CNT=4, trig_pc=0x00003010 seen at stage 3 on the 10th write -> triggered=1; DONE after write 14; 14 entries read, trigger entry is 5th from last.
- Backpressure: drain with rd_ready toggling 1,0,0,1 -> rd_data held during 0 cycles; no entry lost or duplicated.
- start and stop in the same cycle while DONE -> state CAPTURE, count 0, triggered/overflow cleared.
- reset driven low mid-POST -> next cycle IDLE, all outputs 0; a subsequent start captures normally.
